// File: rtl/key_event_uart_tx_pkg.sv
// Shared definitions for the key-event UART transmitter: event byte layout,
// transmitter state encoding and the event byte builder.
package key_event_uart_tx_pkg;

   localparam int EV_STATE_BIT = 7;
   localparam int EV_IDX_MSB   = 3;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_t;

   // Event byte: bit7 = 1 press / 0 release, bits 6:4 zero, bits 3:0 key index.
   function automatic logic [7:0] make_event(input logic state, input logic [EV_IDX_MSB:0] idx);
      logic [7:0] ev;
      ev                 = '0;
      ev[EV_STATE_BIT]   = state;
      ev[EV_IDX_MSB:0]   = idx;
      return ev;
   endfunction

endpackage

// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter with a valid/ready byte interface; accepts the next byte
// during the last stop-bit cycle so consecutive frames have no idle gap.
module uart_tx_8n1
   import key_event_uart_tx_pkg::*;
#(
   parameter int bit_clks = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data,
   input  logic       valid,
   output logic       ready,
   output logic       txd,
   output logic       active
);

   localparam int            CW   = (bit_clks > 1) ? $clog2(bit_clks) : 1;
   localparam logic [CW-1:0] LAST = CW'(bit_clks - 1);

   tx_state_t     state;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic          bit_done;

   assign bit_done = (cnt == LAST);
   assign ready    = (state == TX_IDLE) || ((state == TX_STOP) && bit_done);
   assign active   = (state != TX_IDLE);

   // NOTE: every register here is state, so non-blocking assignments only;
   // txd is registered so the line never glitches on state decode.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= TX_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
         txd     <= 1'b1;
      end else begin
         case (state)
            TX_IDLE: begin
               if (valid) begin
                  shift <= data;
                  cnt   <= '0;
                  txd   <= 1'b0;
                  state <= TX_START;
               end
            end
            TX_START: begin
               if (bit_done) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  txd     <= shift[0];
                  state   <= TX_DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            TX_DATA: begin
               if (bit_done) begin
                  cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     txd   <= 1'b1;
                     state <= TX_STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     shift   <= {1'b0, shift[7:1]};
                     txd     <= shift[1];
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            TX_STOP: begin
               if (bit_done) begin
                  cnt <= '0;
                  if (valid) begin
                     shift <= data;
                     txd   <= 1'b0;
                     state <= TX_START;
                  end else begin
                     state <= TX_IDLE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= TX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/key_event_uart_tx.sv
// Debounces key inputs and reports every press/release as one 8N1 UART byte,
// buffering simultaneous changes through pending flags and an event FIFO.
module key_event_uart_tx
   import key_event_uart_tx_pkg::*;
#(
   parameter int clk_freq       = 50000000,
   parameter int uart_baud_rate = 115200,
   parameter int num_keys       = 13,
   parameter int debounce_clks  = 50000,
   parameter int fifo_depth     = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [num_keys-1:0] keys_in,
   output logic [num_keys-1:0] key_state,
   output logic                uart_txd,
   output logic                busy,
   output logic                overflow
);

   localparam int             BITCLKS = clk_freq / uart_baud_rate;
   localparam int             DW      = (debounce_clks > 1) ? $clog2(debounce_clks) : 1;
   localparam logic [DW-1:0]  DB_LAST = DW'(debounce_clks - 1);
   localparam int             AW      = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
   localparam int             CNTW    = AW + 1;
   localparam logic [CNTW-1:0] FIFO_FULL = CNTW'(fifo_depth);

   // ---------------- synchronizer and debouncer ----------------
   logic [num_keys-1:0] sync1, sync2, accept;
   logic [DW-1:0]       db_cnt [num_keys];

   always_comb begin
      accept = '0;
      for (int i = 0; i < num_keys; i++)
         accept[i] = (sync2[i] != key_state[i]) && (db_cnt[i] == DB_LAST);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1     <= '0;
         sync2     <= '0;
         key_state <= '0;
         for (int i = 0; i < num_keys; i++) db_cnt[i] <= '0;
      end else begin
         sync1     <= keys_in;
         sync2     <= sync1;
         key_state <= key_state ^ accept;
         for (int i = 0; i < num_keys; i++) begin
            if ((sync2[i] == key_state[i]) || accept[i]) db_cnt[i] <= '0;
            else                                         db_cnt[i] <= db_cnt[i] + 1'b1;
         end
      end
   end

   // ---------------- pending flags and lowest-index arbiter ----------------
   logic [num_keys-1:0] pending, grant, served;
   logic                found, grant_state, push, pop;
   logic [3:0]          grant_idx;
   logic [7:0]          push_data;
   logic                fifo_full, fifo_valid;

   // NOTE: every variable gets a default before the loop, so no latch is inferred.
   always_comb begin
      found       = 1'b0;
      grant       = '0;
      grant_idx   = '0;
      grant_state = 1'b0;
      for (int i = 0; i < num_keys; i++) begin
         if (pending[i] && !found) begin
            found       = 1'b1;
            grant[i]    = 1'b1;
            grant_idx   = 4'(i);
            grant_state = key_state[i];
         end
      end
   end

   assign push      = found && !fifo_full;
   assign served    = push ? grant : '0;
   assign push_data = make_event(grant_state, grant_idx);

   // A change on a key being pushed this cycle re-arms its flag after the push.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending  <= '0;
         overflow <= 1'b0;
      end else begin
         pending <= (pending & ~served) | accept;
         if (|(accept & pending & ~served)) overflow <= 1'b1;
      end
   end

   // ---------------- event FIFO ----------------
   logic [7:0]      mem [fifo_depth];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CNTW-1:0] count;
   logic            tx_ready, tx_active;

   assign fifo_full  = (count == FIFO_FULL);
   assign fifo_valid = (count != '0);
   assign pop        = fifo_valid && tx_ready;

   // NOTE: the storage array is not reset; count guarantees no stale entry is read.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   // ---------------- transmitter ----------------
   uart_tx_8n1 #(
      .bit_clks (BITCLKS)
   ) u_tx (
      .clk    (clk),
      .rst    (rst),
      .data   (mem[rd_ptr]),
      .valid  (fifo_valid),
      .ready  (tx_ready),
      .txd    (uart_txd),
      .active (tx_active)
   );

   assign busy = tx_active | fifo_valid;

endmodule

// File: tb/tb_key_event_uart_tx.sv
// Self-checking bench: randomized key patterns and glitches, a serial-line
// receiver, and an expected-event queue built from press/release rules.
module tb_key_event_uart_tx;

   localparam int NK    = 13;
   localparam int BIT   = 43;
   localparam int FRAME = 10 * BIT;

   logic          clk = 1'b0;
   logic          rst;
   logic [NK-1:0] keys_in, key_state, stable;
   logic          uart_txd, busy, overflow;

   int         pass_cnt = 0;
   int         total_cnt = 0;
   int         cyc = 0;
   logic [7:0] rx_q[$];
   logic [7:0] exp_q[$];
   int         start_q[$];
   logic       frame_abort = 1'b0;

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   key_event_uart_tx #(
      .clk_freq       (50000000),
      .uart_baud_rate (1152000),
      .num_keys       (NK),
      .debounce_clks  (100),
      .fifo_depth     (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .keys_in   (keys_in),
      .key_state (key_state),
      .uart_txd  (uart_txd),
      .busy      (busy),
      .overflow  (overflow)
   );

   // Serial receiver: samples mid-bit, drops frames cut by a reset.
   always @(posedge rst) frame_abort = 1'b1;

   initial begin : rx_monitor
      logic [7:0] b;
      logic       framed;
      forever begin
         @(negedge uart_txd);
         frame_abort = 1'b0;
         start_q.push_back(cyc);
         repeat (BIT / 2) @(negedge clk);
         framed = (uart_txd == 1'b0);
         for (int i = 0; i < 8; i++) begin
            repeat (BIT) @(negedge clk);
            b[i] = uart_txd;
         end
         repeat (BIT) @(negedge clk);
         framed = framed && (uart_txd == 1'b1);
         if (!frame_abort) begin
            total_cnt++;
            if (!framed) $display("FAIL framing: byte %02h got bad start/stop, required start=0 stop=1", b);
            else pass_cnt++;
            rx_q.push_back(b);
         end
      end
   end

   // Reference model: each key whose level differs yields one byte, lowest index first.
   function automatic void expect_changes(input logic [NK-1:0] from_v, input logic [NK-1:0] to_v);
      for (int i = 0; i < NK; i++)
         if (from_v[i] !== to_v[i]) exp_q.push_back({to_v[i], 3'b000, 4'(i)});
   endfunction

   task automatic wait_drain(input int n, input int budget, output bit ok);
      int k = 0;
      while ((rx_q.size() < n || busy) && k < budget) begin
         @(negedge clk);
         k++;
      end
      ok = (rx_q.size() >= n) && !busy;
   endtask

   task automatic test_reset();
      int bad = 0;
      rst     = 1'b1;
      keys_in = '0;
      stable  = '0;
      repeat (3) @(negedge clk);
      total_cnt++; if (uart_txd !== 1'b1) $display("FAIL reset_txd: got %b required 1", uart_txd); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else pass_cnt++;
      total_cnt++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b required 0", overflow); else pass_cnt++;
      total_cnt++; if (key_state !== '0) $display("FAIL reset_key_state: got %h required 0", key_state); else pass_cnt++;
      rst = 1'b0;
      repeat (200) begin
         @(negedge clk);
         if (uart_txd !== 1'b1 || busy !== 1'b0) bad++;
      end
      total_cnt++; if (bad != 0) $display("FAIL reset_idle: got %0d active cycles required 0", bad); else pass_cnt++;
   endtask

   task automatic test_single_key();
      int n = 0, m = 0, bad = 0;
      bit ok;
      logic [7:0] e, a;
      logic [7:0] byte_v = 8'h80;
      logic       want;
      keys_in = 13'b1;
      while (!key_state[0] && n < 300) begin
         @(negedge clk);
         n++;
      end
      total_cnt++; if (n != 102) $display("FAIL debounce_latency: got %0d cycles required 102", n); else pass_cnt++;
      while (uart_txd && m < 10) begin
         @(negedge clk);
         m++;
      end
      total_cnt++; if (m != 2) $display("FAIL start_latency: got %0d cycles required 2", m); else pass_cnt++;
      for (int c = 0; c < FRAME; c++) begin
         if (c / BIT == 0)      want = 1'b0;
         else if (c / BIT == 9) want = 1'b1;
         else                   want = byte_v[c / BIT - 1];
         if (uart_txd !== want) bad++;
         @(negedge clk);
      end
      total_cnt++; if (bad != 0) $display("FAIL frame_waveform: got %0d wrong cycles required 0", bad); else pass_cnt++;
      expect_changes(stable, 13'b1);
      stable = 13'b1;
      wait_drain(exp_q.size(), 2 * FRAME, ok);
      total_cnt++; if (!ok) $display("FAIL single_timeout: got %0d frames required %0d", rx_q.size(), exp_q.size()); else pass_cnt++;
      while (exp_q.size() > 0 && rx_q.size() > 0) begin
         e = exp_q.pop_front();
         a = rx_q.pop_front();
         total_cnt++; if (a !== e) $display("FAIL single_byte: got %02h required %02h", a, e); else pass_cnt++;
      end
      exp_q.delete();
      rx_q.delete();
   endtask

   task automatic test_glitch();
      int bad = 0;
      bit ok;
      logic [7:0] e, a;
      keys_in = stable | 13'h020;
      repeat (50) @(negedge clk);
      keys_in = stable;
      repeat (200) begin
         @(negedge clk);
         if (key_state !== stable || uart_txd !== 1'b1 || busy !== 1'b0) bad++;
      end
      total_cnt++; if (bad != 0) $display("FAIL glitch_ignored: got %0d disturbed cycles required 0", bad); else pass_cnt++;
      // Return to all-released for the following scenarios.
      keys_in = '0;
      expect_changes(stable, '0);
      stable = '0;
      wait_drain(exp_q.size(), 2 * FRAME + 300, ok);
      total_cnt++; if (!ok) $display("FAIL release0_timeout: got %0d frames required %0d", rx_q.size(), exp_q.size()); else pass_cnt++;
      while (exp_q.size() > 0 && rx_q.size() > 0) begin
         e = exp_q.pop_front();
         a = rx_q.pop_front();
         total_cnt++; if (a !== e) $display("FAIL release0_byte: got %02h required %02h", a, e); else pass_cnt++;
      end
      exp_q.delete();
      rx_q.delete();
   endtask

   task automatic test_back_to_back(input logic [NK-1:0] to_v);
      bit ok;
      int bad = 0;
      int nexp;
      logic [7:0] e, a;
      start_q.delete();
      keys_in = to_v;
      expect_changes(stable, to_v);
      stable = to_v;
      nexp = exp_q.size();
      wait_drain(nexp, (nexp + 1) * FRAME + 300, ok);
      total_cnt++; if (!ok) $display("FAIL b2b_timeout: got %0d frames required %0d", rx_q.size(), nexp); else pass_cnt++;
      while (exp_q.size() > 0 && rx_q.size() > 0) begin
         e = exp_q.pop_front();
         a = rx_q.pop_front();
         total_cnt++; if (a !== e) $display("FAIL b2b_byte: got %02h required %02h", a, e); else pass_cnt++;
      end
      total_cnt++; if (rx_q.size() != 0) $display("FAIL b2b_extra: got %0d extra frames required 0", rx_q.size()); else pass_cnt++;
      for (int i = 1; i < start_q.size(); i++)
         if (start_q[i] - start_q[i-1] != FRAME) bad++;
      total_cnt++; if (bad != 0 || start_q.size() != nexp) $display("FAIL b2b_gap: got %0d bad gaps over %0d frames required 0 over %0d", bad, start_q.size(), nexp); else pass_cnt++;
      total_cnt++; if (overflow !== 1'b0) $display("FAIL b2b_overflow: got %b required 0", overflow); else pass_cnt++;
      total_cnt++; if (key_state !== stable) $display("FAIL b2b_key_state: got %h required %h", key_state, stable); else pass_cnt++;
      exp_q.delete();
      rx_q.delete();
   endtask

   task automatic test_random();
      logic [NK-1:0] new_v, glitch;
      bit ok;
      int k, p, nexp;
      logic [7:0] e, a;
      for (int it = 0; it < 5; it++) begin
         new_v = NK'($urandom);
         if (new_v == stable) new_v[$urandom_range(0, NK-1)] = ~new_v[0];
         if (new_v == stable) new_v = ~stable;
         k = $urandom_range(0, NK-1);
         p = $urandom_range(1, 60);
         glitch = '0;
         glitch[k] = 1'b1;
         keys_in = stable ^ glitch;
         repeat (p) @(negedge clk);
         keys_in = stable;
         repeat (10) @(negedge clk);
         keys_in = new_v;
         expect_changes(stable, new_v);
         stable = new_v;
         nexp = exp_q.size();
         wait_drain(nexp, (nexp + 1) * FRAME + 300, ok);
         total_cnt++; if (!ok) $display("FAIL random_timeout: got %0d frames required %0d", rx_q.size(), nexp); else pass_cnt++;
         while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front();
            a = rx_q.pop_front();
            total_cnt++; if (a !== e) $display("FAIL random_byte: got %02h required %02h", a, e); else pass_cnt++;
         end
         total_cnt++; if (rx_q.size() != 0) $display("FAIL random_extra: got %0d extra frames required 0", rx_q.size()); else pass_cnt++;
         total_cnt++; if (key_state !== stable) $display("FAIL random_key_state: got %h required %h", key_state, stable); else pass_cnt++;
         exp_q.delete();
         rx_q.delete();
      end
      total_cnt++; if (overflow !== 1'b0) $display("FAIL random_overflow: got %b required 0", overflow); else pass_cnt++;
   endtask

   task automatic test_overflow();
      int n = 0;
      bit ok;
      int nexp;
      logic [7:0] e, a;
      keys_in = 13'h0FFF;
      repeat (5) @(negedge clk);
      keys_in = 13'h1FFF;
      while (!key_state[12] && n < 300) begin
         @(negedge clk);
         n++;
      end
      total_cnt++; if (!key_state[12]) $display("FAIL ovf_press_timeout: got key12=%b required 1", key_state[12]); else pass_cnt++;
      total_cnt++; if (overflow !== 1'b0) $display("FAIL ovf_early: got %b required 0", overflow); else pass_cnt++;
      repeat (150) @(negedge clk);
      keys_in = 13'h0FFF;
      n = 0;
      while (key_state[12] && n < 300) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      total_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_set: got %b required 1", overflow); else pass_cnt++;
      // Key 12 is reported once with its latest (released) level.
      expect_changes(stable, 13'h0FFF);
      exp_q.push_back(8'h0C);
      stable = 13'h0FFF;
      nexp = exp_q.size();
      wait_drain(nexp, (nexp + 1) * FRAME + 300, ok);
      total_cnt++; if (!ok) $display("FAIL ovf_timeout: got %0d frames required %0d", rx_q.size(), nexp); else pass_cnt++;
      while (exp_q.size() > 0 && rx_q.size() > 0) begin
         e = exp_q.pop_front();
         a = rx_q.pop_front();
         total_cnt++; if (a !== e) $display("FAIL ovf_byte: got %02h required %02h", a, e); else pass_cnt++;
      end
      total_cnt++; if (rx_q.size() != 0) $display("FAIL ovf_extra: got %0d extra frames required 0", rx_q.size()); else pass_cnt++;
      total_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b required 1", overflow); else pass_cnt++;
      exp_q.delete();
      rx_q.delete();
   endtask

   task automatic test_reset_mid_frame();
      int n = 0, bad = 0;
      keys_in = '0;
      while (uart_txd && n < 300) begin
         @(negedge clk);
         n++;
      end
      total_cnt++; if (uart_txd !== 1'b0) $display("FAIL mid_frame_start: got txd=%b required 0", uart_txd); else pass_cnt++;
      repeat (100) @(negedge clk);
      #3 rst = 1'b1;
      #1;
      total_cnt++; if (uart_txd !== 1'b1) $display("FAIL mid_reset_txd: got %b required 1", uart_txd); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL mid_reset_busy: got %b required 0", busy); else pass_cnt++;
      total_cnt++; if (overflow !== 1'b0) $display("FAIL mid_reset_overflow: got %b required 0", overflow); else pass_cnt++;
      total_cnt++; if (key_state !== '0) $display("FAIL mid_reset_key_state: got %h required 0", key_state); else pass_cnt++;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      stable = '0;
      repeat (700) begin
         @(negedge clk);
         if (uart_txd !== 1'b1 || busy !== 1'b0) bad++;
      end
      total_cnt++; if (bad != 0) $display("FAIL post_reset_idle: got %0d active cycles required 0", bad); else pass_cnt++;
      total_cnt++; if (rx_q.size() != 0) $display("FAIL post_reset_frames: got %0d frames required 0", rx_q.size()); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_single_key();
      test_glitch();
      test_back_to_back(13'b101);
      test_back_to_back(13'b000);
      test_back_to_back(13'h1FFF);
      test_back_to_back(13'h0000);
      test_random();
      test_back_to_back(13'h0000);
      test_overflow();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
